// File: rtl/jk_pkg.sv
// Shared definitions for the JK drive sequencer: command opcodes, FSM
// state encoding, J/K drive patterns and the expected-Q helper.
package jk_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_RESET  = 2'd1,
        OP_SET    = 2'd2,
        OP_TOGGLE = 2'd3
    } jk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_REPORT = 2'd3
    } jk_state_e;

    // {J,K} drive patterns
    localparam logic [1:0] JK_IDLE   = 2'b00;
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Map an opcode onto its {J,K} drive pattern.
    function automatic logic [1:0] jk_pattern(input jk_op_e op);
        logic [1:0] pat;
        case (op)
            OP_HOLD:   pat = JK_HOLD;
            OP_RESET:  pat = JK_RESET;
            OP_SET:    pat = JK_SET;
            OP_TOGGLE: pat = JK_TOGGLE;
            default:   pat = JK_IDLE;
        endcase
        return pat;
    endfunction

    // Q the flop should show after the drive. A toggle run of CNT+1 cycles
    // flips Q an odd number of times exactly when CNT is even.
    function automatic logic expected_q(input jk_op_e op, input logic q0,
                                        input logic cnt_lsb);
        logic q;
        case (op)
            OP_HOLD:   q = q0;
            OP_RESET:  q = 1'b0;
            OP_SET:    q = 1'b1;
            OP_TOGGLE: q = q0 ^ ~cnt_lsb;
            default:   q = q0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/jk_rep_cnt.sv
// Loadable repeat down-counter with a zero flag. Decrement stops at zero
// so the full range of CNT_W gives 2^CNT_W drive cycles without wrapping.
module jk_rep_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins over decrement, decrement saturates at zero.
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/jk_drive_seq.sv
// JK flip-flop drive sequencer: accepts a command, drives J/K with the
// opcode pattern for CNT+1 cycles, optionally checks the flop's Q, then
// pulses DONE. Define JK_DRIVE_CHECK_EN to include the CHECK state and the
// sticky ERR flag; without it ERR is tied low and Q_FB is not used.
module jk_drive_seq
    import jk_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [CNT_W-1:0] CMD_CNT,
    output logic             J,
    output logic             K,
    input  logic             Q_FB,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

`ifdef JK_DRIVE_CHECK_EN
    localparam jk_state_e AFTER_DRIVE = ST_CHECK;
`else
    localparam jk_state_e AFTER_DRIVE = ST_REPORT;
`endif

    jk_state_e  state_r;
    jk_state_e  state_s;
    jk_op_e     op_r;
    jk_op_e     drive_op_s;
    logic       accept_s;
    logic       dec_s;
    logic       zero_s;
    logic [1:0] jk_s;
    logic       j_r;
    logic       k_r;
    logic       ready_r;
    logic       busy_r;
    logic       done_r;

    jk_rep_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
        .clock    (CLK),
        .rst      (RST),
        .load     (accept_s),
        .load_val (CMD_CNT),
        .dec      (dec_s),
        .zero     (zero_s)
    );

    // Next-state logic; the counter is loaded with CNT so DRIVE spans CNT+1 cycles.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        dec_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    accept_s = 1'b1;
                    state_s  = ST_DRIVE;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (zero_s) begin
                    state_s = AFTER_DRIVE;
                end else begin
                    dec_s   = 1'b1;
                    state_s = ST_DRIVE;
                end
            end
`ifdef JK_DRIVE_CHECK_EN
            ST_CHECK:  state_s = ST_REPORT;
`endif
            ST_REPORT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Drive pattern for the coming cycle; the first DRIVE cycle uses the opcode being accepted.
    always_comb begin
        drive_op_s = op_r;
        jk_s       = JK_IDLE;
        if (accept_s) begin
            drive_op_s = jk_op_e'(CMD_OP);
        end else begin
            drive_op_s = op_r;
        end
        if (state_s == ST_DRIVE) begin
            jk_s = jk_pattern(drive_op_s);
        end else begin
            jk_s = JK_IDLE;
        end
    end

    // State register and outputs registered from the next state so they align with it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            j_r     <= 1'b0;
            k_r     <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            j_r     <= jk_s[1];
            k_r     <= jk_s[0];
            ready_r <= (state_s == ST_IDLE);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_REPORT);
        end
    end

    // Latch the opcode on acceptance.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_r <= OP_HOLD;
        end else if (accept_s) begin
            op_r <= jk_op_e'(CMD_OP);
        end else begin
            op_r <= op_r;
        end
    end

`ifdef JK_DRIVE_CHECK_EN
    logic q0_r;
    logic cnt_lsb_r;
    logic err_r;

    // Capture the flop's starting Q and the count parity when a command is accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q0_r      <= 1'b0;
            cnt_lsb_r <= 1'b0;
        end else if (accept_s) begin
            q0_r      <= Q_FB;
            cnt_lsb_r <= CMD_CNT[0];
        end else begin
            q0_r      <= q0_r;
            cnt_lsb_r <= cnt_lsb_r;
        end
    end

    // Sticky error: set on a Q mismatch in CHECK, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_CHECK) &&
                     (Q_FB != expected_q(op_r, q0_r, cnt_lsb_r))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign ERR = err_r;
`else
    logic q_fb_unused_s;
    assign q_fb_unused_s = Q_FB;
    assign ERR           = 1'b0;
`endif

    assign CMD_READY = ready_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign J         = j_r;
    assign K         = k_r;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Self-checking bench for jk_drive_seq with a behavioural JK flop on J/K.
// Works with or without JK_DRIVE_CHECK_EN defined.
module tb_jk_drive_seq;

    localparam int CNT_W = 4;
`ifdef JK_DRIVE_CHECK_EN
    localparam int EXTRA = 3;
    localparam bit CHK   = 1'b1;
`else
    localparam int EXTRA = 2;
    localparam bit CHK   = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [CNT_W-1:0] CMD_CNT;
    logic             J;
    logic             K;
    logic             Q_FB;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    logic q_flop;
    logic flop_clr;
    logic stuck_en;
    logic stuck_val;
    logic err_exp;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int               lat;
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
        logic             q0;
    } exp_t;
    exp_t sb[$];

    jk_drive_seq #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_CNT   (CMD_CNT),
        .J         (J),
        .K         (K),
        .Q_FB      (Q_FB),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Downstream JK flop, optionally overridden by a stuck value.
    always @(posedge CLK) begin
        if (flop_clr) q_flop <= 1'b0;
        else begin
            case ({J, K})
                2'b01:   q_flop <= 1'b0;
                2'b10:   q_flop <= 1'b1;
                2'b11:   q_flop <= ~q_flop;
                default: q_flop <= q_flop;
            endcase
        end
    end
    assign Q_FB = stuck_en ? stuck_val : q_flop;

    function automatic logic exp_q(input logic [1:0] op, input logic q0,
                                   input logic [CNT_W-1:0] cnt);
        logic [CNT_W:0] n;
        n = {1'b0, cnt} + 1;
        case (op)
            2'd0:    return q0;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return q0 ^ n[0];
        endcase
    endfunction

    task automatic clear_flop();
        @(negedge CLK);
        flop_clr = 1'b1;
        @(negedge CLK);
        flop_clr = 1'b0;
    endtask

    // One command: push expectation, check every cycle, pop on DONE.
    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                           input bit hold_valid);
        exp_t e;
        bit   seen;
        int   limit;
        @(negedge CLK);
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++; $display("FAIL ready_before_cmd: got %b expected 1", CMD_READY);
        end
        CMD_VALID = 1'b1; CMD_OP = op; CMD_CNT = cnt;
        e.lat = int'(cnt) + EXTRA; e.op = op; e.cnt = cnt; e.q0 = Q_FB;
        sb.push_back(e);
        seen  = 1'b0;
        limit = int'(cnt) + EXTRA + 4;
        for (int cyc = 1; cyc <= limit && !seen; cyc++) begin
            @(negedge CLK);
            checks++;
            if ({J, K} !== ((cyc <= int'(cnt) + 1) ? op : 2'b00)) begin
                errors++;
                $display("FAIL jk_cycle%0d op%0d cnt%0d: got %b expected %b", cyc, op, cnt,
                         {J, K}, ((cyc <= int'(cnt) + 1) ? op : 2'b00));
            end
            checks++;
            if ({BUSY, CMD_READY} !== 2'b10) begin
                errors++; $display("FAIL busy_ready_cycle%0d: got %b expected 10", cyc, {BUSY, CMD_READY});
            end
            if (CHK && cyc == int'(cnt) + 2 && sb.size() > 0)
                if (Q_FB !== exp_q(sb[0].op, sb[0].q0, sb[0].cnt)) err_exp = 1'b1;
            if (DONE === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                checks++;
                if (cyc != e.lat) begin
                    errors++; $display("FAIL done_latency: got %0d expected %0d", cyc, e.lat);
                end
                checks++;
                if (ERR !== err_exp) begin
                    errors++; $display("FAIL err_at_done: got %b expected %b", ERR, err_exp);
                end
                CMD_VALID = 1'b0;
            end
            if (cyc == 1 && !hold_valid) begin
                CMD_VALID = 1'b0;
                CMD_OP    = 2'($urandom_range(3, 0));
                CMD_CNT   = CNT_W'($urandom_range(15, 0));
            end
        end
        CMD_VALID = 1'b0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", limit);
            sb.delete();
        end
        @(negedge CLK);
        checks++;
        if ({DONE, BUSY, CMD_READY} !== 3'b001) begin
            errors++; $display("FAIL after_done_idle: got %b expected 001", {DONE, BUSY, CMD_READY});
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_CNT = '0;
        flop_clr = 1'b1; stuck_en = 1'b0; stuck_val = 1'b0; err_exp = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0; flop_clr = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if ({J, K, CMD_READY, BUSY, DONE, ERR} !== 6'b001000) begin
                errors++;
                $display("FAIL reset_idle: got %b expected 001000", {J, K, CMD_READY, BUSY, DONE, ERR});
            end
        end
    endtask

    task automatic test_set();
        run_cmd(2'd2, 4'd0, 1'b0);
        checks++;
        if (q_flop !== 1'b1) begin
            errors++; $display("FAIL set_q: got %b expected 1", q_flop);
        end
    endtask

    task automatic test_toggle();
        clear_flop();
        run_cmd(2'd3, 4'd2, 1'b0);
        checks++;
        if (q_flop !== 1'b1) begin
            errors++; $display("FAIL toggle_q: got %b expected 1", q_flop);
        end
        run_cmd(2'd3, 4'd3, 1'b0);
        checks++;
        if (q_flop !== 1'b1) begin
            errors++; $display("FAIL toggle_even_q: got %b expected 1", q_flop);
        end
    endtask

    task automatic test_stuck();
        stuck_en = 1'b1; stuck_val = 1'b1;
        run_cmd(2'd1, 4'd0, 1'b0);
        stuck_en = 1'b0;
        clear_flop();
        run_cmd(2'd2, 4'd1, 1'b0);
        checks++;
        if (ERR !== err_exp) begin
            errors++; $display("FAIL err_sticky: got %b expected %b", ERR, err_exp);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(2'd0, 4'd15, 1'b1);
        run_cmd(2'd1, 4'd1, 1'b1);
    endtask

    task automatic test_abort();
        bit done_seen;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = 2'd3; CMD_CNT = 4'd5;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        checks++;
        if ({J, K, BUSY} !== 3'b111) begin
            errors++; $display("FAIL abort_drive1: got %b expected 111", {J, K, BUSY});
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; err_exp = 1'b0;
        checks++;
        if ({J, K, BUSY, DONE, CMD_READY, ERR} !== 6'b000010) begin
            errors++;
            $display("FAIL abort_idle: got %b expected 000010", {J, K, BUSY, DONE, CMD_READY, ERR});
        end
        done_seen = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: got %b expected 0", done_seen);
        end
        RST = 1'b1; CMD_VALID = 1'b1; CMD_OP = 2'd2; CMD_CNT = 4'd3;
        @(negedge CLK);
        RST = 1'b0; CMD_VALID = 1'b0;
        checks++;
        if ({BUSY, CMD_READY} !== 2'b01) begin
            errors++; $display("FAIL rst_priority: got %b expected 01", {BUSY, CMD_READY});
        end
        run_cmd(2'd2, 4'd3, 1'b0);
        checks++;
        if (q_flop !== 1'b1) begin
            errors++; $display("FAIL post_abort_q: got %b expected 1", q_flop);
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle();
        test_stuck();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
